// File: rtl/sync_fifo_flag.sv
// Single-clock FIFO with full/empty/almost flags, occupancy count and overflow/underflow pulses.
// Build option: define SYNC_FIFO_BYPASS_EN to pass data_in straight to data_out on a read+write into an empty FIFO.
module sync_fifo_flag #(
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                wr_en,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic                rd_en,
    output logic [DATA_LEN-1:0] data_out,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_WIDTH:0] count,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_LEN-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_LEN-1:0]   data_out_q, data_out_d;
    logic                  full_q, empty_q, almost_full_q, almost_empty_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  rd_ok, wr_ok, byp;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        rd_ok = rd_en && !empty_q;
`ifdef SYNC_FIFO_BYPASS_EN
        byp   = rd_en && wr_en && empty_q;
`else
        byp   = 1'b0;
`endif
        // A write into a full FIFO is accepted only if a read frees a slot at the same edge.
        wr_ok = wr_en && (!full_q || rd_ok) && !byp;

        wr_addr_d = wr_ok ? next_ptr(wr_addr_q) : wr_addr_q;
        rd_addr_d = rd_ok ? next_ptr(rd_addr_q) : rd_addr_q;

        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_ONE;
        end

        data_out_d = data_out_q;
        if (rd_ok) begin
            data_out_d = mem_q[rd_addr_q];
        end else if (byp) begin
            data_out_d = data_in;
        end

        overflow_d  = wr_en && !wr_ok && !byp;
        underflow_d = rd_en && !rd_ok && !byp;
    end

    // Storage has no reset; writes are gated off while reset is held.
    always_ff @(posedge clk) begin
        if (wr_ok && sys_rst_n) begin
            mem_q[wr_addr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            full_q         <= (count_d == DEPTH_C);
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= AFULL_C);
            almost_empty_q <= (count_d <= AEMPTY_C);
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign data_out     = data_out_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
